id_inst_buffer: RTL and testbench
=================================

Name: id_inst_buffer

Overview:
- Parametrised instruction queue between IF and ID. Replaces the single-entry IF/ID latch.
- Captures the {pc, inst} pair each cycle IF presents one, so that instruction SRAM read data returned during an ID stall is not lost.
- Delivers entries in order to ID with a valid/ready handshake.
- Supports whole-queue flush on redirect and keeps a sticky overflow error flag.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PC_W, 32, program counter width
- INST_W, 32, instruction word width
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  discard all held entries (branch/jump redirect)
- in_valid  in  1  IF presents {in_pc, in_inst} this cycle
- in_pc  in  PC_W  pc of presented instruction
- in_inst  in  INST_W  instruction word (inst_sram_rdata)
- in_ready  out  1  buffer accepts a push this cycle
- out_valid  out  1  head entry valid
- out_pc  out  PC_W  head pc
- out_inst  out  INST_W  head instruction
- out_ready  in  1  ID consumes head this cycle (ID not stalled)
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow_err  out  1  sticky: push attempted while full

Behaviour:
Reset (async, rst=1):
- Pointers = 0, count = 0, out_valid = 0, out_pc = 0, out_inst = 0, overflow_err = 0.
- Storage contents are don't-care.

Handshake rules:
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (count != 0).
- out_pc/out_inst = head entry when out_valid, else all-zero (a bubble, same convention as the zeroed IF/ID bus).

Latency:
- Push into an empty buffer appears at the outputs on the next cycle. There is no same-cycle bypass.
- Pop advances the head on the clock edge; the next entry is visible the following cycle.

Per-cycle update (priority order):
1. flush=1: count <- 0, rd_ptr <- wr_ptr. Any same-cycle push and pop are discarded; nothing is written.
2. Otherwise:
   - push only: write at wr_ptr, wr_ptr+1, count+1.
   - pop only: rd_ptr+1, count-1.
   - push & pop together: both pointers advance, count unchanged.
   - neither: hold.

Pointers:
- Width $clog2(DEPTH); wrap modulo DEPTH naturally.
- count is tracked separately to disambiguate full from empty.

Full:
- in_ready=0, even if a pop occurs the same cycle. No push-when-full-with-pop.
- in_valid=1 while full sets overflow_err=1. The flag stays set until rst. The entry is dropped and state is unchanged.

Empty:
- out_ready is ignored and no pop occurs. count never underflows.

Flush while empty: no effect other than dropping a same-cycle push.

Delay slot: flush discards everything held. The issuer asserts flush only after the delay-slot instruction has been popped.

Reset asserted mid-operation: all state clears immediately (asynchronously). Outputs show a bubble until the first push after rst deasserts.

Decomposition:
- Shared defines header gets:
  - IB_DEPTH (default 4)
  - IB_ENTRY_WD = PC_W+INST_W (64)
  - IF_TO_IB_WD for the {in_valid, in_pc, in_inst} bundle
  - IB_TO_ID_WD for {out_valid, out_pc, out_inst}
- No sub-module. Storage is a DEPTH x IB_ENTRY_WD register array inside the block, about 150 lines of RTL.

Test Plan:
1. Reset then single push: rst pulse; push pc=0xBFC00000, inst=0x3C011234 with out_ready=0 -> next cycle out_valid=1, out_pc=0xBFC00000, out_inst=0x3C011234, count=1, in_ready=1.
2. Fill and overflow: DEPTH=4, out_ready=0, push pcs 0x00,0x04,0x08,0x0C -> count=4, in_ready=0. A fifth in_valid -> overflow_err=1, count stays 4. Draining then returns pcs 0x00,0x04,0x08,0x0C in order.
3. Simultaneous push/pop at count=2: push pc=0x10 while popping -> count stays 2, head advances. The sequence over 8 cycles wraps both pointers, with no loss or duplication.
4. Flush priority: count=3, flush=1 with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, out_pc=0, out_inst=0. The flushed pc is never output.
5. Full with pop: count=4, in_valid=1, out_ready=1 -> pop happens, push is refused, count=3, overflow_err=1.
6. Async reset mid-stream: assert rst between clock edges with count=2 -> count=0 and out_valid=0 before the next edge. overflow_err clears.

Source files
------------

// File: rtl/id_inst_buffer_pkg.sv
// Shared widths for the IF -> instruction buffer -> ID path.
package id_inst_buffer_pkg;

    // Default queue depth. Must be a power of two and at least 2.
    localparam int unsigned IB_DEPTH    = 4;
    localparam int unsigned IB_PC_W     = 32;
    localparam int unsigned IB_INST_W   = 32;

    // One stored entry is {pc, inst}.
    localparam int unsigned IB_ENTRY_WD = IB_PC_W + IB_INST_W;

    // {in_valid, in_pc, in_inst} as presented by IF.
    localparam int unsigned IF_TO_IB_WD = 1 + IB_ENTRY_WD;

    // {out_valid, out_pc, out_inst} as seen by ID.
    localparam int unsigned IB_TO_ID_WD = 1 + IB_ENTRY_WD;

endpackage

// File: rtl/id_inst_buffer.sv
// Instruction queue between IF and ID. Holds {pc, inst} pairs so that SRAM
// read data returned while ID is stalled is kept, and hands them to ID in
// order over a valid/ready handshake. Flush drops everything held.
module id_inst_buffer
    import id_inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = IB_DEPTH,
    parameter int unsigned PC_W   = IB_PC_W,
    parameter int unsigned INST_W = IB_INST_W,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow_err
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, wr_en;
    logic [ENTRY_W-1:0] head;

    // Handshake decode; in_ready depends only on registered occupancy.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wr_en     = push & ~flush;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        // A push attempt while full is dropped but remembered until reset.
        overflow_d = overflow_q | (in_valid & ~in_ready);
        if (flush) begin
            // Redirect: empty the queue by catching the read side up.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                2'b01: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                2'b11: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {in_pc, in_inst};
        end
    end

    // Head entry, or an all-zero bubble when the queue is empty.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_pc   = out_valid ? head[ENTRY_W-1:INST_W] : '0;
        out_inst = out_valid ? head[INST_W-1:0]       : '0;
    end

    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_id_inst_buffer.sv
// Directed and random checks of id_inst_buffer against a queue-based model.
module tb_id_inst_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow_err;

    id_inst_buffer #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .INST_W(INST_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-order list of held {pc, inst} plus sticky flag.
    logic [63:0] mq[$];
    bit          m_ovf;
    int          vectors;
    int          miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        check({tag, ".count"},     64'(count),        64'(mq.size()));
        check({tag, ".out_valid"}, 64'(out_valid),    64'(mq.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),     64'(mq.size() != DEPTH));
        check({tag, ".out_pc"},    64'(out_pc),       {32'h0, head[63:32]});
        check({tag, ".out_inst"},  64'(out_inst),     {32'h0, head[31:0]});
        check({tag, ".ovf"},       64'(overflow_err), 64'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic f, input logic iv,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy);
        bit full, empty;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (iv && full) m_ovf = 1'b1;
        if (f) begin
            mq.delete();
        end else begin
            if (ordy && !empty) void'(mq.pop_front());
            if (iv && !full) mq.push_back({pc, inst});
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        m_ovf = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("por");

        // 1. Single push into empty buffer, visible next cycle.
        step("t1_push", 1'b0, 1'b1, 32'hBFC0_0000, 32'h3C01_1234, 1'b0);
        check("t1_pc_const", 64'(out_pc), 64'hBFC0_0000);
        check("t1_inst_const", 64'(out_inst), 64'h3C01_1234);
        step("t1_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // 2. Fill, overflow, drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("t2_fill", 1'b0, 1'b1, 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0);
        end
        check("t2_full_count", 64'(count), 64'd4);
        step("t2_over", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_0000, 1'b0);
        check("t2_ovf_const", 64'(overflow_err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_pc", 64'(out_pc), 64'(i * 4));
            step("t2_drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        end
        step("t2_empty_pop", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // 3. Simultaneous push/pop at count=2 wraps both pointers.
        do_reset();
        step("t3_a", 1'b0, 1'b1, 32'h0000_0008, 32'h3000_0008, 1'b0);
        step("t3_b", 1'b0, 1'b1, 32'h0000_000C, 32'h3000_000C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("t3_pp", 1'b0, 1'b1, 32'h10 + 32'(i * 4), 32'h3100_0000 + 32'(i), 1'b1);
        end
        check("t3_count_const", 64'(count), 64'd2);
        for (int i = 0; i < 3; i++) step("t3_drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // 4. Flush beats a same-cycle push and pop.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step("t4_fill", 1'b0, 1'b1, 32'h40 + 32'(i * 4), 32'h4000_0000 + 32'(i), 1'b0);
        end
        step("t4_flush", 1'b1, 1'b1, 32'hFFFF_0000, 32'h4444_4444, 1'b1);
        check("t4_pc_zero", 64'(out_pc), 64'd0);
        step("t4_after", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step("t4_flush_empty", 1'b1, 1'b1, 32'h0000_0050, 32'h5, 1'b0);
        step("t4_after2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // 5. Full with pop: pop happens, push refused, flag sets.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("t5_fill", 1'b0, 1'b1, 32'h80 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b0);
        end
        step("t5_fullpop", 1'b0, 1'b1, 32'h0000_0090, 32'h5555_5555, 1'b1);
        check("t5_count_const", 64'(count), 64'd3);
        check("t5_ovf_const", 64'(overflow_err), 64'd1);

        // 6. Asynchronous reset between edges clears state at once.
        step("t6_pop", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("t6_count2", 64'(count), 64'd2);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #3 rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        check_all("t6_async");
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("t6_release");

        // Random traffic with phases favouring fill or drain.
        for (int i = 0; i < 600; i++) begin
            logic f, iv, ordy;
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
            step("rand", f, iv, $urandom, $urandom, ordy);
            if (i == 300) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
